// File: rtl/nonce_sequencer_pkg.sv
// nonce_sequencer_pkg
// Shared definitions for the nonce sequencer:
//   - SHA256_IV      : SHA-256 initial hash value. It is the start state for the outer hash.
//   - INNER_MSG_LEN  : bit length of the 80-byte block header, which is 640.
//   - OUTER_MSG_LEN  : bit length of the 32-byte inner digest, which is 256.
//   - state_e        : sequencer FSM state encoding.
//   - bswap32()      : 32-bit byte swap. The nonce is placed in the message little-endian.
package nonce_sequencer_pkg;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [63:0] INNER_MSG_LEN = 64'd640;
  localparam logic [63:0] OUTER_MSG_LEN = 64'd256;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_INNER_START = 3'd1,
    ST_INNER_WAIT  = 3'd2,
    ST_OUTER_START = 3'd3,
    ST_OUTER_WAIT  = 3'd4,
    ST_CHECK       = 3'd5,
    ST_REPORT      = 3'd6,
    ST_DRAIN       = 3'd7
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/nonce_sequencer_target_compare.sv
// target_compare
// Combinational difficulty check. The SHA-256 digest is byte-reversed, so result[255:248]
// becomes the least significant byte. The reversed value is then compared, unsigned,
// against the target.
// Ports:
//   result  in  256  outer SHA-256 digest, as produced by the core
//   target  in  256  difficulty target
//   found   out 1    high when the byte-reversed digest is <= target
module target_compare (
  input  logic [255:0] result,
  input  logic [255:0] target,
  output logic         found
);

  logic [255:0] hash_le;

  for (genvar i = 0; i < 32; i++) begin : g_bswap
    assign hash_le[8*i +: 8] = result[255-8*i -: 8];
  end

  assign found = (hash_le <= target);

endmodule

// File: rtl/nonce_sequencer.sv
// nonce_sequencer
// Steps a nonce across an inclusive 32-bit range. For every nonce it runs a double SHA-256
// on an external sha_core: the inner hash starts from the job midstate, and the outer hash
// starts from the IV. It reports nonces whose reversed digest meets the target.
// Optional build macro: NONCE_SEQUENCER_STATS_EN adds the hash_count output.
// Ports:
//   clk, rst (async, active-low)
//   job_*  / nonce_start / nonce_end : job handshake and payload
//   abort                            : cancel the current job
//   core_start_state / core_message / core_start / core_done / core_result : sha_core link
//   found_valid / found_ready / found_nonce / found_hash : solution handshake
//   busy, exhausted                  : status
//   hash_count (STATS_EN only)       : saturating count of completed checks
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a job; job_ready high
// INNER_START | start pulse for the inner hash (midstate + header tail)
// INNER_WAIT  | wait for the inner digest
// OUTER_START | start pulse for the outer hash (IV + inner digest)
// OUTER_WAIT  | wait for the outer digest
// CHECK       | compare the digest with the target, then pick the next nonce
// REPORT      | hold the solution until found_ready
// DRAIN       | aborted while the core was busy; wait out its done, then go to IDLE
module nonce_sequencer
  import nonce_sequencer_pkg::*;
#(
  parameter int unsigned NONCE_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_tail,
  input  logic [255:0] job_target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         abort,
  output logic [255:0] core_start_state,
  output logic [511:0] core_message,
  output logic         core_start,
  input  logic         core_done,
  input  logic [255:0] core_result,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         busy,
  output logic         exhausted
`ifdef NONCE_SEQUENCER_STATS_EN
  ,
  output logic [31:0]  hash_count
`endif
);

  localparam logic [31:0] STEP = 32'(NONCE_STEP);

  state_e       state_q, state_d;
  logic [255:0] midstate_q, target_q, inner_q, outer_q;
  logic [95:0]  tail_q;
  logic [31:0]  nonce_q, nonce_end_q;
  logic         start_d_q;
  logic         outer_phase_q;

  logic         done_ok, is_last, found;
  logic         load_job, advance, cap_inner, cap_outer;

  // A done seen in the cycle right after a start belongs to the previous operation.
  assign done_ok = core_done && !start_d_q;
  assign is_last = ((nonce_end_q - nonce_q) < STEP);

  target_compare u_target_compare (
    .result (outer_q),
    .target (target_q),
    .found  (found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // An abort in a START state suppresses the pulse. This means no hash is left
  // in flight when the sequencer drops straight back to IDLE.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    exhausted  = 1'b0;
    load_job   = 1'b0;
    advance    = 1'b0;
    cap_inner  = 1'b0;
    cap_outer  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          load_job = 1'b1;
          state_d  = ST_INNER_START;
        end
      end
      ST_INNER_START: begin
        if (abort) state_d = ST_IDLE;
        else begin
          core_start = 1'b1;
          state_d    = ST_INNER_WAIT;
        end
      end
      ST_INNER_WAIT: begin
        if (done_ok) begin
          if (abort) state_d = ST_IDLE;
          else begin
            cap_inner = 1'b1;
            state_d   = ST_OUTER_START;
          end
        end else if (abort) state_d = ST_DRAIN;
      end
      ST_OUTER_START: begin
        if (abort) state_d = ST_IDLE;
        else begin
          core_start = 1'b1;
          state_d    = ST_OUTER_WAIT;
        end
      end
      ST_OUTER_WAIT: begin
        if (done_ok) begin
          if (abort) state_d = ST_IDLE;
          else begin
            cap_outer = 1'b1;
            state_d   = ST_CHECK;
          end
        end else if (abort) state_d = ST_DRAIN;
      end
      ST_CHECK: begin
        if (abort) state_d = ST_IDLE;
        else if (found) state_d = ST_REPORT;
        else if (is_last) begin
          exhausted = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          advance = 1'b1;
          state_d = ST_INNER_START;
        end
      end
      ST_REPORT: begin
        if (abort) state_d = ST_IDLE;
        else if (found_ready) begin
          if (is_last) begin
            exhausted = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            advance = 1'b1;
            state_d = ST_INNER_START;
          end
        end
      end
      ST_DRAIN: begin
        if (done_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_d_q     <= 1'b0;
      midstate_q    <= '0;
      tail_q        <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      inner_q       <= '0;
      outer_q       <= '0;
      outer_phase_q <= 1'b0;
    end else begin
      start_d_q <= core_start;
      if (load_job) begin
        midstate_q    <= job_midstate;
        tail_q        <= job_tail;
        target_q      <= job_target;
        nonce_q       <= nonce_start;
        nonce_end_q   <= nonce_end;
        outer_phase_q <= 1'b0;
      end
      if (advance) begin
        nonce_q       <= nonce_q + STEP;
        outer_phase_q <= 1'b0;
      end
      if (cap_inner) begin
        inner_q       <= core_result;
        outer_phase_q <= 1'b1;
      end
      if (cap_outer) outer_q <= core_result;
    end
  end

  // The core inputs are decoded from registered state, so they stay put for the
  // whole operation. This includes DRAIN, where outer_phase_q picks which one was in flight.
  always_comb begin
    core_start_state = '0;
    core_message     = '0;
    unique case (state_q)
      ST_INNER_START, ST_INNER_WAIT: begin
        core_start_state = midstate_q;
        core_message     = {tail_q, bswap32(nonce_q), 1'b1, 319'b0, INNER_MSG_LEN};
      end
      ST_OUTER_START, ST_OUTER_WAIT: begin
        core_start_state = SHA256_IV;
        core_message     = {inner_q, 1'b1, 191'b0, OUTER_MSG_LEN};
      end
      ST_DRAIN: begin
        if (outer_phase_q) begin
          core_start_state = SHA256_IV;
          core_message     = {inner_q, 1'b1, 191'b0, OUTER_MSG_LEN};
        end else begin
          core_start_state = midstate_q;
          core_message     = {tail_q, bswap32(nonce_q), 1'b1, 319'b0, INNER_MSG_LEN};
        end
      end
      default: ;
    endcase
  end

  assign job_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign found_valid = (state_q == ST_REPORT);
  assign found_nonce = found_valid ? nonce_q : 32'd0;
  assign found_hash  = found_valid ? outer_q : 256'd0;

`ifdef NONCE_SEQUENCER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hash_count <= '0;
    else if (state_q == ST_CHECK && !abort && hash_count != 32'hFFFF_FFFF)
      hash_count <= hash_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_nonce_sequencer.sv
module tb_nonce_sequencer;

  localparam int LAT = 6;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] MID =
    256'h4A03AEB2_BCF3AD77_D705828C_4EC62FA2_282784A2_85936A72_C71636A4_DDEF7254;
  localparam logic [95:0]  TAIL = 96'h15274c64_6c51f957_c4400418;
  localparam logic [31:0]  N0   = 32'hcb4f9a9c;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid, job_ready;
  logic [255:0] job_midstate, job_target;
  logic [95:0]  job_tail;
  logic [31:0]  nonce_start, nonce_end;
  logic         abort;
  logic [255:0] core_start_state;
  logic [511:0] core_message;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [255:0] core_result = '0;
  logic         found_valid, found_ready;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         busy, exhausted;
`ifdef NONCE_SEQUENCER_STATS_EN
  logic [31:0]  hash_count;
`endif

  nonce_sequencer #(.NONCE_STEP(1)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_tail(job_tail), .job_target(job_target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
    .core_start_state(core_start_state), .core_message(core_message),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .found_valid(found_valid), .found_ready(found_ready),
    .found_nonce(found_nonce), .found_hash(found_hash),
    .busy(busy), .exhausted(exhausted)
`ifdef NONCE_SEQUENCER_STATS_EN
    , .hash_count(hash_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // sha_core model: a stale done with garbage data in the cycle after start,
  // then the real digest LAT cycles later. A new start restarts the model.
  int           model_cnt = 0;
  logic [255:0] pending = '0;
  always @(posedge clk) begin
    if (core_start) begin
      pending     <= sha256_compress(core_start_state, core_message);
      core_done   <= 1'b1;
      core_result <= {8{32'hdeadbeef}};
      model_cnt   <= LAT;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      core_done <= (model_cnt == 1);
      if (model_cnt == 1) core_result <= pending;
    end else begin
      core_done <= 1'b0;
    end
  end

  int n_chk = 0, n_err = 0;
  int n_start = 0, n_exh = 0, n_fv = 0, n_real_done = 0, n_start_in_report = 0, n_unstable = 0;
  logic [31:0]  found_q [$];
  logic [511:0] start_msgs [$];
  logic [255:0] start_states [$];
  logic         prev_start = 1'b0, track = 1'b0;
  logic [511:0] t_msg;
  logic [255:0] t_st;

  always @(posedge clk) begin
    if (core_start) begin
      n_start++;
      start_msgs.push_back(core_message);
      start_states.push_back(core_start_state);
    end
    if (exhausted) n_exh++;
    if (found_valid) n_fv++;
    if (found_valid && found_ready) found_q.push_back(found_nonce);
    if (core_start && found_valid) n_start_in_report++;
    if (core_done && !prev_start) n_real_done++;
    if (!rst) track = 1'b0;
    else if (core_start) begin
      track = 1'b1; t_msg = core_message; t_st = core_start_state;
    end else if (track) begin
      if (core_message !== t_msg || core_start_state !== t_st) n_unstable++;
      if (core_done && !prev_start) track = 1'b0;
    end
    prev_start = core_start;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_job(input logic [255:0] tgt, input logic [31:0] ns, input logic [31:0] ne);
    int t = 0;
    while (!job_ready && t < 100) begin @(negedge clk); t++; end
    chk("job_ready_wait", job_ready, 1);
    job_valid = 1'b1; job_midstate = MID; job_tail = TAIL; job_target = tgt;
    nonce_start = ns; nonce_end = ne;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_found(input string tag);
    int t = 0;
    while (!found_valid && t < 200) begin @(negedge clk); t++; end
    chk(tag, found_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 300) begin @(negedge clk); t++; end
    chk(tag, busy, 0);
  endtask

  task automatic ack();
    found_ready = 1'b1;
    @(negedge clk);
    found_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [255:0] T192, TONES, inner_exp, hash_exp;
  logic [511:0] inner_msg_exp, outer_msg_exp;
  logic [31:0]  exp_n [4];
  int s0, e0, f0, d0;
  logic [31:0] hc0;

  initial begin
    T192  = {64'h0, {192{1'b1}}};
    TONES = {256{1'b1}};
    inner_msg_exp = {TAIL, 32'h9c9a4fcb, 1'b1, 319'b0, 64'd640};
    inner_exp     = sha256_compress(MID, inner_msg_exp);
    outer_msg_exp = {inner_exp, 1'b1, 191'b0, 64'd256};
    hash_exp      = sha256_compress(IV, outer_msg_exp);
    exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    hc0 = '0;

    rst = 1'b0; job_valid = 1'b0; job_midstate = '0; job_tail = '0; job_target = '0;
    nonce_start = '0; nonce_end = '0; abort = 1'b0; found_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_found_valid", found_valid, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_core_message", core_message, 0);
    chk("rst_found_hash", found_hash, 0);
`ifdef NONCE_SEQUENCER_STATS_EN
    chk("rst_hash_count", hash_count, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Known solution, single nonce
    start_msgs.delete(); start_states.delete();
    s0 = n_start; e0 = n_exh;
    send_job(T192, N0, N0);
    wait_found("known_found");
    chk("known_nonce", found_nonce, N0);
    chk("known_hash_top", found_hash[255:224], 32'hd87daf3f);
    chk("known_hash_low", found_hash[63:0], 64'h0);
    chk("known_hash_full", found_hash, hash_exp);
    chk("inner_msg", start_msgs.size() > 0 ? start_msgs[0] : 512'hx, inner_msg_exp);
    chk("inner_state", start_states.size() > 0 ? start_states[0] : 256'hx, MID);
    chk("outer_msg", start_msgs.size() > 1 ? start_msgs[1] : 512'hx, outer_msg_exp);
    chk("outer_state", start_states.size() > 1 ? start_states[1] : 256'hx, IV);
    repeat (5) @(negedge clk);
    chk("report_hold_valid", found_valid, 1);
    chk("report_hold_nonce", found_nonce, N0);
    chk("report_no_start", n_start - s0, 2);
    ack();
    wait_idle("known_idle");
    chk("known_exhausted", n_exh - e0, 1);

    // Same job, impossible target
    s0 = n_start; e0 = n_exh; f0 = n_fv;
    send_job(256'h0, N0, N0);
    wait_idle("t0_idle");
    chk("t0_starts", n_start - s0, 2);
    chk("t0_no_found", n_fv - f0, 0);
    chk("t0_exhausted", n_exh - e0, 1);

    // Wrap-around range with a stalled report; reset first so hash_count starts at 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    found_q.delete();
    e0 = n_exh;
    send_job(TONES, 32'hFFFFFFFE, 32'h00000001);
    for (int k = 0; k < 4; k++) begin
      wait_found("wrap_found");
      if (k == 1) begin
        s0 = n_start;
        repeat (20) @(negedge clk);
        chk("stall_no_start", n_start - s0, 0);
        chk("stall_valid", found_valid, 1);
        chk("stall_nonce", found_nonce, 32'hFFFFFFFF);
      end
      ack();
    end
    wait_idle("wrap_idle");
    chk("wrap_count", found_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("wrap_nonce", i < found_q.size() ? found_q[i] : 32'hx, exp_n[i]);
    chk("wrap_exhausted", n_exh - e0, 1);
`ifdef NONCE_SEQUENCER_STATS_EN
    chk("stats_after_wrap", hash_count, 4);
    hc0 = hash_count;
`endif

    // Abort during INNER_WAIT
    e0 = n_exh; f0 = n_fv; d0 = n_real_done;
    send_job(T192, N0, N0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("drain_job_ready", job_ready, 0);
    chk("drain_busy", busy, 1);
    wait_idle("drain_idle");
    chk("drain_done_seen", n_real_done - d0, 1);
    chk("abort_no_exhausted", n_exh - e0, 0);
    chk("abort_no_found", n_fv - f0, 0);
`ifdef NONCE_SEQUENCER_STATS_EN
    chk("stats_after_abort", hash_count, hc0);
`endif
    e0 = n_exh;
    send_job(T192, N0, N0);
    wait_found("post_abort_found");
    chk("post_abort_nonce", found_nonce, N0);
    chk("post_abort_hash", found_hash, hash_exp);
    ack();
    wait_idle("post_abort_idle");
    chk("post_abort_exhausted", n_exh - e0, 1);

    // Reset during OUTER_WAIT
    s0 = n_start;
    send_job(T192, N0, N0);
    begin
      int t = 0;
      while (n_start - s0 < 2 && t < 100) begin @(negedge clk); t++; end
    end
    chk("outer_reached", n_start - s0, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_job_ready", job_ready, 1);
    chk("rst2_busy", busy, 0);
    chk("rst2_core_start", core_start, 0);
    chk("rst2_core_message", core_message, 0);
    chk("rst2_core_state", core_start_state, 0);
    chk("rst2_found_valid", found_valid, 0);
`ifdef NONCE_SEQUENCER_STATS_EN
    chk("rst2_hash_count", hash_count, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    e0 = n_exh;
    send_job(T192, N0, N0);
    wait_found("post_rst_found");
    chk("post_rst_nonce", found_nonce, N0);
    chk("post_rst_hash", found_hash, hash_exp);
    ack();
    wait_idle("post_rst_idle");
    chk("post_rst_exhausted", n_exh - e0, 1);

    chk("no_start_in_report", n_start_in_report, 0);
    chk("core_inputs_stable", n_unstable, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
